vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 SHALL have parameter H_SYNC, default 96, meaning HS low width in pixel clocks.
REQ-002 SHALL have parameter H_BACK, default 48, meaning back porch width in pixel clocks.
REQ-003 SHALL have parameter H_ACT, default 640, meaning active pixels per line.
REQ-004 SHALL have parameter H_TOTAL, default 800, meaning pixel clocks per line.
REQ-005 SHALL have parameters V_SYNC=2, V_BACK=33, V_ACT=480 and V_TOTAL=525, meaning the same quantities in lines.
REQ-006 SHALL have port CLK, input, 1 bit, pixel clock; this is the single clock.
REQ-007 SHALL have port RST, input, 1 bit; reset is asynchronous and active-high.
REQ-008 SHALL have ports VGA_HS and VGA_VS, input, 1 bit each, active-low syncs.
REQ-009 SHALL have ports VGA_R, VGA_G and VGA_B, input, 4 bits each, pixel colour.
REQ-010 SHALL have ports PIX_R, PIX_G and PIX_B, output, 4 bits each, captured colour.
REQ-011 SHALL have ports REC_X and REC_Y, output, 11 bits each, recovered coordinates.
REQ-012 SHALL have port PIX_VALID, output, 1 bit, asserted for an active pixel while locked.
REQ-013 SHALL have port FRAME_START, output, 1 bit, one-cycle pulse.
REQ-014 SHALL have port LOCKED, output, 1 bit, timing matches the parameters.
REQ-015 SHALL have ports H_MEAS and V_MEAS, output, 11 bits each, last measured line length and frame length.
REQ-016 SHALL have port ERR_CNT, output, 8 bits, count of lock losses.

Function
REQ-017 SHALL register all VGA_* inputs once (stage 1); edges SHALL be detected as a stage-1 falling edge (current 0, previous 1).
REQ-018 SHALL clear h_cnt to 0 on the cycle the HS falling edge is detected; otherwise h_cnt SHALL increment, saturating at 2047.
REQ-019 SHALL, on each HS edge, load H_MEAS with the old h_cnt+1; v_cnt SHALL be 0 if a VS falling edge is pending or coincident, else v_cnt+1.
REQ-020 SHALL, at a VS edge, load V_MEAS with the line count of the finished frame and pulse FRAME_START for one cycle.
REQ-021 SHALL drive REC_X = h_cnt-(H_SYNC+H_BACK) and REC_Y = v_cnt-(V_SYNC+V_BACK), in 11-bit wrap arithmetic; active when REC_X<H_ACT and REC_Y<V_ACT.
REQ-022 SHALL use a fixed latency: a pixel on the pins at cycle n appears on PIX_*, REC_* and PIX_VALID at cycle n+2.
REQ-023 SHALL hold PIX_R/G/B at 0 whenever PIX_VALID is 0.
REQ-024 SHALL implement the lock FSM states SEARCH, MEASURE and LOCKED.
REQ-025 SHALL move SEARCH -> MEASURE on a VS edge.
REQ-026 SHALL, in MEASURE, go MEASURE -> LOCKED at the next VS edge if every line equalled H_TOTAL and the frame equalled V_TOTAL; otherwise it SHALL stay in MEASURE and restart.
REQ-027 SHALL go LOCKED -> SEARCH on any line length != H_TOTAL, frame length != V_TOTAL, or h_cnt reaching 2*H_TOTAL with no HS edge.
REQ-028 SHALL increment ERR_CNT, saturating at 255, on every LOCKED -> SEARCH transition.
REQ-029 SHALL drive LOCKED = 1 only in state LOCKED, and SHALL force PIX_VALID to 0 on the cycle the loss is detected.
REQ-030 SHALL give precedence to the HS clear when HS and VS edges coincide, with v_cnt = 0.

Reset
REQ-031 SHALL, while RST is high, force state SEARCH and all counters, stage registers and outputs to 0, with the previous-sync registers set to 1 (idle high).
REQ-032 SHALL, when RST is asserted mid-frame, drop LOCKED and PIX_VALID asynchronously; relock SHALL then require a full MEASURE frame.

Structure
REQ-033 SHALL place the default timing constants and the FSM state enum in the shared package vga_timing_pkg, which the generator side also uses.
REQ-034 SHALL implement the HS/VS synchronous falling-edge detector as one sub-module, vga_edge_det, instantiated twice.

Verification
REQ-035 SHALL verify nominal lock: drive 3 frames of standard 640x480 timing -> LOCKED rises at the 2nd VS edge, H_MEAS=800, V_MEAS=525, ERR_CNT=0.
REQ-036 SHALL verify pixel mapping: when locked, drive R=h%16 -> PIX_R at REC_X=0 equals the pin value from 2 cycles earlier; 640 PIX_VALID cycles per line, 480 lines.
REQ-037 SHALL verify line error: shorten one line to 799 clocks while locked -> SEARCH, LOCKED=0, ERR_CNT=1, H_MEAS=799.
REQ-038 SHALL verify HS loss: hold HS high for 1600 clocks -> LOCKED=0 at h_cnt=1600 and ERR_CNT increments.
REQ-039 SHALL verify coincident edges: VS and HS fall on the same cycle -> REC_Y restarts at v_cnt=0 and FRAME_START pulses once.
REQ-040 SHALL verify reset mid-frame: RST high for 3 cycles at line 200 -> all outputs 0 immediately; LOCKED is regained only after 2 VS edges.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480 timing constants, lock FSM states and a saturating 11-bit increment
package vga_timing_pkg;
  localparam int H_SYNC_DEF  = 96;
  localparam int H_BACK_DEF  = 48;
  localparam int H_ACT_DEF   = 640;
  localparam int H_TOTAL_DEF = 800;
  localparam int V_SYNC_DEF  = 2;
  localparam int V_BACK_DEF  = 33;
  localparam int V_ACT_DEF   = 480;
  localparam int V_TOTAL_DEF = 525;
  typedef enum logic [1:0] {ST_SEARCH, ST_MEASURE, ST_LOCKED} lock_state_t;
  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7ff) ? v : v + 11'd1;
  endfunction
endpackage

// File: rtl/vga_edge_det.sv
// vga_edge_det: registers an active-low sync once and flags its falling edge; idles high after reset
module vga_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic fall
);
  logic s, prev;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s <= 1'b1;
      prev <= 1'b1;
    end else begin
      s <= d;
      prev <= s;
    end
  assign fall = prev & ~s;
endmodule

// File: rtl/vga_capture.sv
// vga_capture: recovers pixel coordinates from VGA syncs, measures timing and gates pixels on lock
module vga_capture
  import vga_timing_pkg::*;
#(
  parameter int H_SYNC  = H_SYNC_DEF,
  parameter int H_BACK  = H_BACK_DEF,
  parameter int H_ACT   = H_ACT_DEF,
  parameter int H_TOTAL = H_TOTAL_DEF,
  parameter int V_SYNC  = V_SYNC_DEF,
  parameter int V_BACK  = V_BACK_DEF,
  parameter int V_ACT   = V_ACT_DEF,
  parameter int V_TOTAL = V_TOTAL_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        VGA_HS,
  input  logic        VGA_VS,
  input  logic [3:0]  VGA_R,
  input  logic [3:0]  VGA_G,
  input  logic [3:0]  VGA_B,
  output logic [3:0]  PIX_R,
  output logic [3:0]  PIX_G,
  output logic [3:0]  PIX_B,
  output logic [10:0] REC_X,
  output logic [10:0] REC_Y,
  output logic        PIX_VALID,
  output logic        FRAME_START,
  output logic        LOCKED,
  output logic [10:0] H_MEAS,
  output logic [10:0] V_MEAS,
  output logic [7:0]  ERR_CNT
);
  localparam logic [10:0] X_OFF  = 11'(H_SYNC + H_BACK);
  localparam logic [10:0] Y_OFF  = 11'(V_SYNC + V_BACK);
  localparam logic [10:0] H_LEN  = 11'(H_TOTAL);
  localparam logic [10:0] V_LEN  = 11'(V_TOTAL);
  localparam logic [10:0] H_LOST = 11'(2 * H_TOTAL);
  lock_state_t state;
  logic hs_fall, vs_fall, vs_pend, line_ok, bad_line, loss, vld;
  logic [3:0] r_s, g_s, b_s;
  logic [10:0] h_cnt, v_cnt, h_len, v_len, h_nxt, v_nxt, x_nxt, y_nxt;
  vga_edge_det u_hs (.clk(CLK), .rst(RST), .d(VGA_HS), .fall(hs_fall));
  vga_edge_det u_vs (.clk(CLK), .rst(RST), .d(VGA_VS), .fall(vs_fall));
  // counters run one stage ahead so coordinates line up with the stage-1 pixel
  always_comb begin
    h_len = sat_inc(h_cnt);
    v_len = sat_inc(v_cnt);
    h_nxt = hs_fall ? '0 : h_len;
    v_nxt = hs_fall ? ((vs_fall || vs_pend) ? '0 : v_len) : v_cnt;
    x_nxt = h_nxt - X_OFF;
    y_nxt = v_nxt - Y_OFF;
    bad_line = hs_fall && h_len != H_LEN;
    loss = state == ST_LOCKED && (bad_line || (vs_fall && v_len != V_LEN) || h_cnt == H_LOST);
    vld = state == ST_LOCKED && !loss && x_nxt < 11'(H_ACT) && y_nxt < 11'(V_ACT);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= ST_SEARCH;
      line_ok <= 1'b0;
      vs_pend <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
      r_s <= '0;
      g_s <= '0;
      b_s <= '0;
      PIX_R <= '0;
      PIX_G <= '0;
      PIX_B <= '0;
      REC_X <= '0;
      REC_Y <= '0;
      PIX_VALID <= 1'b0;
      FRAME_START <= 1'b0;
      H_MEAS <= '0;
      V_MEAS <= '0;
      ERR_CNT <= '0;
    end else begin
      r_s <= VGA_R;
      g_s <= VGA_G;
      b_s <= VGA_B;
      h_cnt <= h_nxt;
      v_cnt <= v_nxt;
      vs_pend <= !hs_fall && (vs_pend || vs_fall);
      if (hs_fall) H_MEAS <= h_len;
      if (vs_fall) V_MEAS <= v_len;
      FRAME_START <= vs_fall;
      REC_X <= x_nxt;
      REC_Y <= y_nxt;
      PIX_VALID <= vld;
      PIX_R <= vld ? r_s : '0;
      PIX_G <= vld ? g_s : '0;
      PIX_B <= vld ? b_s : '0;
      case (state)
        ST_SEARCH:
          if (vs_fall) begin
            state <= ST_MEASURE;
            line_ok <= 1'b1;
          end
        ST_MEASURE:
          if (vs_fall) begin
            state <= (line_ok && !bad_line && v_len == V_LEN) ? ST_LOCKED : ST_MEASURE;
            line_ok <= 1'b1;
          end else if (bad_line) line_ok <= 1'b0;
        ST_LOCKED:
          if (loss) begin
            state <= ST_SEARCH;
            ERR_CNT <= (ERR_CNT == 8'hff) ? ERR_CNT : ERR_CNT + 8'd1;
          end
        default: state <= ST_SEARCH;
      endcase
    end
  assign LOCKED = state == ST_LOCKED;
endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed checks of lock, pixel mapping, loss, coincident edges and reset on scaled timing
module tb_vga_capture;
  localparam int H_SYNC = 4, H_BACK = 4, H_ACT = 16, H_TOTAL = 32;
  localparam int V_SYNC = 2, V_BACK = 2, V_ACT = 8, V_TOTAL = 14;
  logic CLK = 1'b0, RST = 1'b1, VGA_HS = 1'b1, VGA_VS = 1'b1;
  logic [3:0] VGA_R = '0, VGA_G = '0, VGA_B = '0;
  logic [3:0] PIX_R, PIX_G, PIX_B;
  logic [10:0] REC_X, REC_Y, H_MEAS, V_MEAS;
  logic PIX_VALID, FRAME_START, LOCKED;
  logic [7:0] ERR_CNT;
  int total = 0, bad = 0;
  int fs_cnt = 0, valid_cnt = 0, row_cnt = 0, map_bad = 0, zero_bad = 0;
  vga_capture #(
    .H_SYNC(H_SYNC), .H_BACK(H_BACK), .H_ACT(H_ACT), .H_TOTAL(H_TOTAL),
    .V_SYNC(V_SYNC), .V_BACK(V_BACK), .V_ACT(V_ACT), .V_TOTAL(V_TOTAL)
  ) dut (
    .CLK(CLK), .RST(RST), .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .PIX_R(PIX_R), .PIX_G(PIX_G), .PIX_B(PIX_B),
    .REC_X(REC_X), .REC_Y(REC_Y), .PIX_VALID(PIX_VALID), .FRAME_START(FRAME_START),
    .LOCKED(LOCKED), .H_MEAS(H_MEAS), .V_MEAS(V_MEAS), .ERR_CNT(ERR_CNT)
  );
  always #5 CLK = ~CLK;
  // stimulus colours are R=pixel, G=line, B=~pixel, so a valid output must map back to its coordinates
  always @(negedge CLK)
    if (!RST) begin
      if (FRAME_START) fs_cnt++;
      if (PIX_VALID) begin
        valid_cnt++;
        if (REC_X == 11'd0) row_cnt++;
        if (PIX_R !== 4'(REC_X + 11'(H_SYNC + H_BACK)) || PIX_G !== 4'(REC_Y + 11'(V_SYNC + V_BACK)) || PIX_B !== ~PIX_R)
          map_bad++;
      end else if ({PIX_R, PIX_G, PIX_B} !== 12'h000) zero_bad++;
    end
  task automatic pix(input int l, input int p);
    VGA_HS = (p >= H_SYNC);
    VGA_VS = (l >= V_SYNC);
    VGA_R = 4'(p);
    VGA_G = 4'(l);
    VGA_B = ~4'(p);
    @(posedge CLK);
    #1;
  endtask
  task automatic line_from(input int l, input int p0, input int len);
    for (int p = p0; p < len; p++) pix(l, p);
  endtask
  task automatic frame_from(input int p0);
    line_from(0, p0, H_TOTAL);
    for (int l = 1; l < V_TOTAL; l++) line_from(l, 0, H_TOTAL);
  endtask
  task automatic lock_up(output logic pre);
    frame_from(0);
    pix(0, 0);
    pre = LOCKED;
    pix(0, 1);
  endtask
  task automatic test_reset;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL reset_locked: got %b want 0", LOCKED); end
    total++; if (PIX_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", PIX_VALID); end
    total++; if (ERR_CNT !== 8'd0) begin bad++; $display("FAIL reset_err: got %0d want 0", ERR_CNT); end
    total++; if ({H_MEAS, V_MEAS} !== 22'd0) begin bad++; $display("FAIL reset_meas: got %0d/%0d want 0/0", H_MEAS, V_MEAS); end
    total++; if ({REC_X, REC_Y, PIX_R, FRAME_START} !== 27'd0) begin bad++; $display("FAIL reset_outs: got x=%0d y=%0d r=%0d fs=%b want 0", REC_X, REC_Y, PIX_R, FRAME_START); end
    RST = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
  endtask
  task automatic test_lock;
    logic pre;
    lock_up(pre);
    total++; if (pre !== 1'b0) begin bad++; $display("FAIL lock_early: got %b want 0", pre); end
    total++; if (LOCKED !== 1'b1) begin bad++; $display("FAIL lock_rise: got %b want 1", LOCKED); end
    total++; if (H_MEAS !== 11'd32) begin bad++; $display("FAIL lock_hmeas: got %0d want 32", H_MEAS); end
    total++; if (V_MEAS !== 11'd14) begin bad++; $display("FAIL lock_vmeas: got %0d want 14", V_MEAS); end
    total++; if (ERR_CNT !== 8'd0) begin bad++; $display("FAIL lock_err: got %0d want 0", ERR_CNT); end
    frame_from(2);
  endtask
  task automatic test_pixel_map;
    valid_cnt = 0; row_cnt = 0; map_bad = 0; zero_bad = 0;
    for (int l = 0; l < V_TOTAL; l++)
      for (int p = 0; p < H_TOTAL; p++) begin
        pix(l, p);
        if (l == 4 && p == 9) begin
          total++; if (REC_X !== 11'd0 || REC_Y !== 11'd0) begin bad++; $display("FAIL map_origin: got %0d,%0d want 0,0", REC_X, REC_Y); end
          total++; if (PIX_VALID !== 1'b1) begin bad++; $display("FAIL map_valid0: got %b want 1", PIX_VALID); end
          total++; if ({PIX_R, PIX_G, PIX_B} !== {4'd8, 4'd4, 4'd7}) begin bad++; $display("FAIL map_pix0: got %h%h%h want 847", PIX_R, PIX_G, PIX_B); end
        end
        if (l == 4 && p == 24) begin
          total++; if (REC_X !== 11'd15 || PIX_R !== 4'd7 || PIX_VALID !== 1'b1) begin bad++; $display("FAIL map_last: got x=%0d r=%0d v=%b want 15 7 1", REC_X, PIX_R, PIX_VALID); end
        end
        if (l == 4 && p == 25) begin
          total++; if (REC_X !== 11'd16 || PIX_R !== 4'd0 || PIX_VALID !== 1'b0) begin bad++; $display("FAIL map_past: got x=%0d r=%0d v=%b want 16 0 0", REC_X, PIX_R, PIX_VALID); end
        end
      end
    total++; if (valid_cnt !== H_ACT * V_ACT) begin bad++; $display("FAIL map_count: got %0d want %0d", valid_cnt, H_ACT * V_ACT); end
    total++; if (row_cnt !== V_ACT) begin bad++; $display("FAIL map_rows: got %0d want %0d", row_cnt, V_ACT); end
    total++; if (map_bad !== 0) begin bad++; $display("FAIL map_colour: got %0d bad pixels want 0", map_bad); end
    total++; if (zero_bad !== 0) begin bad++; $display("FAIL map_blank: got %0d nonzero blanks want 0", zero_bad); end
  endtask
  task automatic test_line_error;
    logic pre;
    for (int l = 0; l < V_TOTAL; l++)
      for (int p = 0; p < ((l == 5) ? H_TOTAL - 1 : H_TOTAL); p++) begin
        pix(l, p);
        if (l == 6 && p == 0) begin
          total++; if (LOCKED !== 1'b1) begin bad++; $display("FAIL lerr_hold: got %b want 1", LOCKED); end
        end
        if (l == 6 && p == 1) begin
          total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL lerr_drop: got %b want 0", LOCKED); end
          total++; if (ERR_CNT !== 8'd1) begin bad++; $display("FAIL lerr_cnt: got %0d want 1", ERR_CNT); end
          total++; if (H_MEAS !== 11'd31) begin bad++; $display("FAIL lerr_hmeas: got %0d want 31", H_MEAS); end
        end
      end
    lock_up(pre);
    total++; if (pre !== 1'b0 || LOCKED !== 1'b1) begin bad++; $display("FAIL lerr_relock: got %b,%b want 0,1", pre, LOCKED); end
    frame_from(2);
  endtask
  task automatic test_hs_loss;
    logic pre;
    line_from(0, 0, H_TOTAL);
    line_from(1, 0, H_TOTAL);
    for (int p = 0; p <= 2 * H_TOTAL + 2; p++) begin
      pix(2, p);
      if (p == 2 * H_TOTAL + 1) begin
        total++; if (LOCKED !== 1'b1) begin bad++; $display("FAIL hsl_hold: got %b want 1", LOCKED); end
      end
    end
    total++; if (LOCKED !== 1'b0) begin bad++; $display("FAIL hsl_drop: got %b want 0", LOCKED); end
    total++; if (ERR_CNT !== 8'd2) begin bad++; $display("FAIL hsl_cnt: got %0d want 2", ERR_CNT); end
    for (int l = 3; l < V_TOTAL; l++) line_from(l, 0, H_TOTAL);
    lock_up(pre);
    total++; if (pre !== 1'b0 || LOCKED !== 1'b1) begin bad++; $display("FAIL hsl_relock: got %b,%b want 0,1", pre, LOCKED); end
    frame_from(2);
  endtask
  task automatic test_coincident;
    fs_cnt = 0;
    pix(0, 0);
    pix(0, 1);
    total++; if (REC_X !== 11'h7f8 || REC_Y !== 11'h7fc) begin bad++; $display("FAIL coin_xy: got %h,%h want 7f8,7fc", REC_X, REC_Y); end
    total++; if (FRAME_START !== 1'b1) begin bad++; $display("FAIL coin_fs: got %b want 1", FRAME_START); end
    pix(0, 2);
    total++; if (FRAME_START !== 1'b0) begin bad++; $display("FAIL coin_fs_end: got %b want 0", FRAME_START); end
    frame_from(3);
    total++; if (fs_cnt !== 1) begin bad++; $display("FAIL coin_fs_count: got %0d want 1", fs_cnt); end
  endtask
  task automatic test_reset_mid;
    logic pre;
    for (int l = 0; l < 6; l++) line_from(l, 0, H_TOTAL);
    line_from(6, 0, 13);
    RST = 1'b1;
    #1;
    total++; if (LOCKED !== 1'b0 || PIX_VALID !== 1'b0) begin bad++; $display("FAIL rmid_drop: got %b,%b want 0,0", LOCKED, PIX_VALID); end
    total++; if ({PIX_R, PIX_G, PIX_B, REC_X, REC_Y} !== 34'd0) begin bad++; $display("FAIL rmid_outs: got x=%0d y=%0d rgb=%h%h%h want 0", REC_X, REC_Y, PIX_R, PIX_G, PIX_B); end
    total++; if ({ERR_CNT, H_MEAS, V_MEAS} !== 30'd0) begin bad++; $display("FAIL rmid_regs: got err=%0d h=%0d v=%0d want 0", ERR_CNT, H_MEAS, V_MEAS); end
    line_from(6, 13, 16);
    RST = 1'b0;
    line_from(6, 16, H_TOTAL);
    for (int l = 7; l < V_TOTAL; l++) line_from(l, 0, H_TOTAL);
    lock_up(pre);
    total++; if (pre !== 1'b0) begin bad++; $display("FAIL rmid_early: got %b want 0", pre); end
    total++; if (LOCKED !== 1'b1 || ERR_CNT !== 8'd0) begin bad++; $display("FAIL rmid_relock: got %b err=%0d want 1 err=0", LOCKED, ERR_CNT); end
    frame_from(2);
  endtask
  initial begin
    test_reset;
    test_lock;
    test_pixel_map;
    test_line_error;
    test_hs_loss;
    test_coincident;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
